// File: rtl/asp.sv
// Single-port network adapter: parity-checked host words are tagged and sent to
// the link with ACK-timeout retransmission; tagged link words go to the host with duplicate suppression.
module asp #(
  parameter int data_size = 32,
  parameter int tag_size  = 8,
  parameter int timeout   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          data_parity_ready_in,
  input  logic [data_size:0]            data_parity_in,
  input  logic                          network_data_ready_in,
  input  logic                          network_ACK_in,
  input  logic [data_size+tag_size-1:0] network_data_tag_in,
  output logic                          parity_error_out,
  output logic                          host_data_ready_out,
  output logic [data_size-1:0]          host_data_out,
  output logic                          network_data_ready_out,
  output logic                          network_ACK_out,
  output logic [data_size+tag_size-1:0] network_data_tag_out
);

  // state | meaning
  // IDLE  | no frame outstanding, accepting a parity-good host word
  // SEND  | frame on the link this cycle, retry timer loaded
  // WAIT  | waiting for ACK, timer counting down to a resend
  typedef enum logic [1:0] {IDLE, SEND, WAIT} tx_state_t;

  localparam int cnt_w = (timeout > 2) ? $clog2(timeout) : 1;

  tx_state_t          state, state_nxt;
  logic [cnt_w-1:0]   cnt, cnt_nxt;
  logic [tag_size-1:0] tx_tag, tx_tag_nxt;
  logic               latch;
  logic               host_ok;
  logic               host_bad;

  logic [tag_size-1:0] last_rx_tag;
  logic                last_rx_valid;
  logic [tag_size-1:0] rx_tag;
  logic                rx_new;

  assign host_ok  = data_parity_ready_in && !(^data_parity_in);
  assign host_bad = data_parity_ready_in && (^data_parity_in);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    tx_tag_nxt = tx_tag;
    latch      = 1'b0;
    case (state)
      IDLE: begin
        if (host_ok) begin
          latch     = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        // timer reaches zero after timeout WAIT cycles, giving a timeout+1 resend period
        cnt_nxt = cnt_w'(timeout - 1);
        if (network_ACK_in) begin
          tx_tag_nxt = tx_tag + tag_size'(1);
          state_nxt  = IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (network_ACK_in) begin
          tx_tag_nxt = tx_tag + tag_size'(1);
          state_nxt  = IDLE;
        end else if (cnt == '0) begin
          state_nxt = SEND;
        end else begin
          cnt_nxt = cnt - cnt_w'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                  <= IDLE;
      cnt                    <= '0;
      tx_tag                 <= '0;
      network_data_ready_out <= 1'b0;
      network_data_tag_out   <= '0;
      parity_error_out       <= 1'b0;
    end else begin
      state                  <= state_nxt;
      cnt                    <= cnt_nxt;
      tx_tag                 <= tx_tag_nxt;
      network_data_ready_out <= (state_nxt == SEND);
      parity_error_out       <= host_bad;
      if (latch)
        network_data_tag_out <= {tx_tag, data_parity_in[data_size:1]};
    end
  end

  assign rx_tag = network_data_tag_in[data_size+tag_size-1:data_size];
  assign rx_new = network_data_ready_in && (!last_rx_valid || (rx_tag != last_rx_tag));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      network_ACK_out     <= 1'b0;
      host_data_ready_out <= 1'b0;
      host_data_out       <= '0;
      last_rx_tag         <= '0;
      last_rx_valid       <= 1'b0;
    end else begin
      network_ACK_out     <= network_data_ready_in;
      host_data_ready_out <= rx_new;
      if (rx_new) begin
        host_data_out <= network_data_tag_in[data_size-1:0];
        last_rx_tag   <= rx_tag;
        last_rx_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_asp.sv
// Directed bench for asp: scoreboard queues hold the outstanding TX frame and
// expected host deliveries; every comparison is an immediate assertion.
module tb_asp;
  localparam int DW = 32;
  localparam int TW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          data_parity_ready_in;
  logic [DW:0]   data_parity_in;
  logic          network_data_ready_in;
  logic          network_ACK_in;
  logic [DW+TW-1:0] network_data_tag_in;
  logic          parity_error_out;
  logic          host_data_ready_out;
  logic [DW-1:0] host_data_out;
  logic          network_data_ready_out;
  logic          network_ACK_out;
  logic [DW+TW-1:0] network_data_tag_out;

  int checks = 0;
  int errors = 0;
  logic [DW+TW-1:0] tx_q[$];
  logic [DW-1:0]    rx_q[$];
  logic [DW-1:0]    last_host;
  logic [TW-1:0]    exp_tag;

  asp #(.data_size(DW), .tag_size(TW), .timeout(TO)) dut (
    .clk(clk), .reset(reset),
    .data_parity_ready_in(data_parity_ready_in), .data_parity_in(data_parity_in),
    .network_data_ready_in(network_data_ready_in), .network_ACK_in(network_ACK_in),
    .network_data_tag_in(network_data_tag_in),
    .parity_error_out(parity_error_out), .host_data_ready_out(host_data_ready_out),
    .host_data_out(host_data_out), .network_data_ready_out(network_data_ready_out),
    .network_ACK_out(network_ACK_out), .network_data_tag_out(network_data_tag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {parity_error_out, host_data_ready_out, network_data_ready_out, network_ACK_out,
                 (host_data_out != 0), (network_data_tag_out != 0)}, 64'd0);
  endtask

  task automatic send_host(input logic [DW-1:0] d, input logic p);
    data_parity_in = {d, p};
    data_parity_ready_in = 1'b1;
    step();
    data_parity_ready_in = 1'b0;
  endtask

  task automatic check_frame(input string name);
    logic [DW+TW-1:0] exp;
    exp = (tx_q.size() != 0) ? tx_q[0] : '0;
    check({name, "_rdy"}, network_data_ready_out, 1'b1);
    check(name, network_data_tag_out, exp);
  endtask

  task automatic wait_tx(input string name, input int gap);
    int n = 0;
    do begin
      step();
      n++;
    end while (!network_data_ready_out && n < 100);
    check({name, "_gap"}, n, gap);
    check_frame(name);
  endtask

  task automatic ack_tx();
    network_ACK_in = 1'b1;
    step();
    network_ACK_in = 1'b0;
    if (tx_q.size() != 0) void'(tx_q.pop_front());
    exp_tag++;
  endtask

  task automatic send_net(input string name, input logic [TW-1:0] t, input logic [DW-1:0] d,
                          input logic is_new);
    logic [DW-1:0] exp;
    network_data_tag_in = {t, d};
    network_data_ready_in = 1'b1;
    if (is_new) rx_q.push_back(d);
    step();
    network_data_ready_in = 1'b0;
    check({name, "_ack"}, network_ACK_out, 1'b1);
    check({name, "_rdy"}, host_data_ready_out, is_new);
    if (is_new && rx_q.size() != 0) last_host = rx_q.pop_front();
    exp = last_host;
    check({name, "_data"}, host_data_out, exp);
  endtask

  initial begin
    logic [DW-1:0] d;
    reset = 1'b0;
    data_parity_ready_in = 1'b0;
    data_parity_in = '0;
    network_data_ready_in = 1'b0;
    network_ACK_in = 1'b0;
    network_data_tag_in = '0;
    last_host = '0;
    exp_tag = '0;
    step();
    step();
    check_all_zero("reset_outputs");
    @(negedge clk) reset = 1'b1;
    step();
    check_all_zero("after_release");

    // first frame, tag 0, retransmitted on timeout
    tx_q.push_back({exp_tag, 32'hA5A5A5A5});
    send_host(32'hA5A5A5A5, 1'b0);
    check("t2_perr", parity_error_out, 1'b0);
    check_frame("t2_first");
    wait_tx("t2_retx1", TO + 1);
    wait_tx("t2_retx2", TO + 1);
    step();
    step();
    ack_tx();
    check("t2_idle_rdy", network_data_ready_out, 1'b0);
    network_ACK_in = 1'b1;
    step();
    network_ACK_in = 1'b0;

    // second frame carries tag 1; ACK during SEND is honoured
    tx_q.push_back({exp_tag, 32'h00000000});
    send_host(32'h00000000, 1'b0);
    check_frame("t2_tag1");
    ack_tx();
    check("t2_ack_send", network_data_ready_out, 1'b0);

    // parity error while idle
    send_host(32'hA5A5A5A5, 1'b1);
    check("t3_perr", parity_error_out, 1'b1);
    check("t3_no_tx", network_data_ready_out, 1'b0);
    step();
    check("t3_pulse_end", parity_error_out, 1'b0);
    step();
    check("t3_still_idle", network_data_ready_out, 1'b0);

    // RX delivery, back-to-back duplicate, new tag
    send_net("t4_new", 8'h07, 32'h12345678, 1'b1);
    send_net("t4_dup", 8'h07, 32'h12345678, 1'b0);
    send_net("t4_tag8", 8'h08, 32'hCAFEF00D, 1'b1);

    // parity error and RX delivery in the same cycle
    data_parity_in = {32'h00000001, 1'b0};
    data_parity_ready_in = 1'b1;
    network_data_tag_in = {8'h09, 32'h0BADBEEF};
    network_data_ready_in = 1'b1;
    step();
    data_parity_ready_in = 1'b0;
    network_data_ready_in = 1'b0;
    last_host = 32'h0BADBEEF;
    check("sim_perr", parity_error_out, 1'b1);
    check("sim_rdy", host_data_ready_out, 1'b1);
    check("sim_data", host_data_out, last_host);
    check("sim_no_tx", network_data_ready_out, 1'b0);

    // good word during WAIT is dropped
    tx_q.push_back({exp_tag, 32'h0F0F0F0F});
    send_host(32'h0F0F0F0F, 1'b0);
    check_frame("t5_frame");
    step();
    d = 32'h12345678;
    send_host(d, ^d);
    check("t5_drop_perr", parity_error_out, 1'b0);
    check("t5_drop_rdy", network_data_ready_out, 1'b0);
    check("t5_hold", network_data_tag_out, tx_q[0]);
    wait_tx("t5_retx", TO - 1);
    ack_tx();

    // 256 acknowledged transmits cover the tag wrap
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      tx_q.push_back({exp_tag, d});
      send_host(d, ^d);
      check_frame("t6_loop");
      ack_tx();
    end
    check("t6_wrapped", exp_tag, 8'd3);

    // async reset mid-WAIT
    tx_q.push_back({exp_tag, 32'h55AA55AA});
    send_host(32'h55AA55AA, 1'b0);
    check_frame("t6_pre_rst");
    step();
    step();
    #2 reset = 1'b0;
    #1 check_all_zero("t6_async_rst");
    void'(tx_q.pop_front());
    exp_tag = '0;
    step();
    check_all_zero("t6_rst_held");
    @(negedge clk) reset = 1'b1;
    step();
    check("t6_no_resend", network_data_ready_out, 1'b0);
    tx_q.push_back({exp_tag, 32'h33333333});
    send_host(32'h33333333, 1'b0);
    check_frame("t6_tag0");
    ack_tx();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
